// File: rtl/reg_bank_pkg.sv
// Shared constants and encodings for the two-requester register bank.
package reg_bank_pkg;

    localparam int DATA_W_DEF   = 4;
    localparam int NUM_REGS_DEF = 4;
    localparam int ADDR_W_DEF   = 2;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/reg_bank_slot.sv
// One bank register: load-enabled storage with asynchronous active-low clear.
module reg_bank_slot #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] q_q;

    // Capture new data on a load, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing a register bank between two requesters.
// One access per cycle; read data returns on a registered one-cycle pulse.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata
);

    req_id_e           rr_q, rr_d;
    logic              grant0, grant1, xfer;
    req_id_e           sel_id;
    op_e               sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_data;
    logic [NUM_REGS-1:0] load;
    logic [DATA_W-1:0] bank [NUM_REGS];

    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

    // Grant: a lone requester always wins; a tie goes opposite the last grant
    always_comb begin
        grant0 = req0_valid && (!req1_valid || rr_q == REQ1);
        grant1 = req1_valid && (!req0_valid || rr_q == REQ0);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;

    // Steer the granted command onto the shared bank path and advance rr
    always_comb begin
        sel_id    = grant1 ? REQ1 : REQ0;
        sel_op    = op_e'(grant1 ? req1_we : req0_we);
        sel_addr  = grant1 ? req1_addr : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
        rr_d      = xfer ? sel_id : rr_q;
    end

    // Write decode; out-of-range addresses match no slot and are dropped
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            load[i] = xfer && (sel_op == OP_WRITE) && (sel_addr == ADDR_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
        reg_bank_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load[g]),
            .d_i    (sel_wdata),
            .q_o    (bank[g])
        );
    end

    // Read mux; out-of-range reads fall through to zero
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (sel_addr == ADDR_W'(i)) begin
                rd_data = bank[i];
            end
        end
    end

    // Response next-state: read transfers launch a pulse, rdata holds otherwise
    always_comb begin
        rsp0_valid_d = grant0 && (sel_op == OP_READ);
        rsp1_valid_d = grant1 && (sel_op == OP_READ);
        rsp0_rdata_d = rsp0_valid_d ? rd_data : rsp0_rdata_q;
        rsp1_rdata_d = rsp1_valid_d ? rd_data : rsp1_rdata_q;
    end

    // rr pointer and response registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= REQ1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            rr_q         <= rr_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares a bank of NUM_REGS small load-enabled registers between two independent requesters, requester 0 and requester 1.
- Each requester can issue single-beat read or write requests using a valid/ready handshake.
- A round-robin arbiter grants at most one access per cycle. Read data returns on a registered response one cycle later.
- The block sits between the two control sequencers and the shared register storage, and owns that storage.

Parameters:
- DATA_W, 4, width of each register and of the data buses.
- NUM_REGS, 4, number of registers in the bank (range 2..16).
- ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a request pending.
- req0_ready  out  1  requester 0 is granted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  register index.
- req0_wdata  in  DATA_W  write data.
- rsp0_valid  out  1  one-cycle pulse: read data for requester 0 is valid.
- rsp0_rdata  out  DATA_W  read data for requester 0.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as the requester 0 ports, for requester 1.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - Reset clears all bank registers, the rr pointer, rsp0/1_valid and rsp0/1_rdata to 0.
- Handshake:
  - A request transfers on a clk edge where reqN_valid && reqN_ready.
  - reqN_ready is combinational from the valids and the rr pointer. It never depends on reqN_we, addr or wdata.
  - A requester holds valid, we, addr and wdata stable until ready is seen.
- Arbitration:
  - Only req0_valid: req0_ready = 1.
  - Only req1_valid: req1_ready = 1.
  - Both valid: grant goes to the requester opposite the rr pointer, where rr = last requester granted.
  - rr resets to 1, so the first tie goes to requester 0.
  - rr updates only on a transfer. With neither valid, rr holds.
  - A lone requester is granted every cycle with no bubbles.
  - Under continuous contention the two requesters strictly alternate.
- Write:
  - On transfer, bank[addr] <= wdata at that edge.
  - A read transferred on the next cycle returns the new value.
  - There is no response for writes.
- Read:
  - On transfer, rspN_rdata <= bank[addr] (the value before the edge), and rspN_valid <= 1 for exactly one cycle.
  - Latency is 1 cycle from the transfer edge.
  - Responses cannot be backpressured.
  - rspN_rdata holds its last value while rspN_valid = 0.
- Out-of-range address (addr >= NUM_REGS): a write is accepted and discarded; a read is accepted and returns 0 with rsp_valid = 1.
- Same-cycle events: only one transfer can occur per cycle, so there are no bank write/read conflicts. The loser keeps valid asserted and is served on the next cycle.
- Reset mid-operation:
  - Any in-flight response is dropped, with rsp_valid forced to 0 immediately (asynchronously).
  - Bank contents are lost.
  - The arbiter restarts with requester 0 as tie winner.
- State: the rr pointer (1 bit), the bank (NUM_REGS x DATA_W), and the two response registers.

Decomposition:
- Package reg_bank_pkg holds:
  - the default DATA_W / NUM_REGS / ADDR_W constants;
  - requester-id constants REQ0 = 0 and REQ1 = 1;
  - an op encoding: OP_READ = 0, OP_WRITE = 1.
- One sub-module, reg_bank_slot: a DATA_W load-enabled register with async active-low clear, instantiated NUM_REGS times.
- Arbitration, address decode and read mux stay in the top module.

Test Plan:
1. Reset, then req0 writes 5 to addr 1; next cycle req0 reads addr 1 -> req0_ready = 1 both cycles; rsp0_valid pulses 1 cycle later with rsp0_rdata = 5; rsp1_valid stays 0.
2. Both valid on the first cycle after reset (req0 reads addr 0, req1 reads addr 2) -> req0 granted first, req1 next cycle; rsp0 and rsp1 each return 0, one cycle apart.
3. Both held valid for 6 cycles -> grants alternate 0,1,0,1,0,1 with no idle cycles; holding only req1 afterwards gives grants every cycle.
4. req0 writes 9 to addr 3 while req1 reads addr 3 in the same cycle (req0 wins the tie) -> req1 is served next cycle and returns 9. Repeat with req1 winning -> the read returns the old value 0... then 9.
5. Write 12 to addr 2, then assert rst_n = 0 for one cycle while a read of addr 2 is in flight -> rsp_valid drops immediately and no pulse appears; after reset, a read of addr 2 returns 0.
6. NUM_REGS = 3: write 7 to addr 3, then read addr 3 -> the write is accepted, the read returns 0, and addr 0..2 are unchanged.
